// File: rtl/semaforo_pkg.sv
// Shared definitions for the pedestrian crossing controller: phase encoding,
// vehicle-light codes and the countdown display helper.
package semaforo_pkg;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    ESPERA   = 2'd1,
    ANDANDO  = 2'd2,
    PISCANDO = 2'd3
  } fase_t;

  localparam logic [1:0] VERDE    = 2'b00;
  localparam logic [1:0] AMARELO  = 2'b01;
  localparam logic [1:0] VERMELHO = 2'b10;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DISP_W = 4;

  // Remaining-cycles display: counter+1, saturated to the 4-bit maximum.
  function automatic logic [DISP_W-1:0] mostrador(input logic [CNT_W-1:0] cnt);
    logic [CNT_W:0] soma;
    soma = (CNT_W+1)'(cnt) + (CNT_W+1)'(1);
    return (soma > (CNT_W+1)'(15)) ? DISP_W'(15) : DISP_W'(soma);
  endfunction

endpackage

// File: rtl/debounce_botao.sv
// Push-button conditioning: 2-flop synchronizer, N-sample debounce and a
// one-cycle pulse on each accepted press.
module debounce_botao #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic subida
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE + 1);

  logic            sync_a;
  logic            sync_b;
  logic            nivel;
  logic [DB_W-1:0] cnt;

  // A sample equal to the accepted level restarts the run of differing samples.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      nivel  <= 1'b0;
      cnt    <= '0;
      subida <= 1'b0;
    end else begin
      sync_a <= entrada;
      sync_b <= sync_a;
      subida <= 1'b0;
      if (sync_b == nivel) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DEBOUNCE - 1)) begin
        nivel  <= sync_b;
        cnt    <= '0;
        subida <= sync_b;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/semaforo_pedestre.sv
// Pedestrian crossing controller: registers a debounced request, asks the
// vehicle light to stop, then runs the walk and flashing phases while red.
module semaforo_pedestre
  import semaforo_pkg::*;
#(
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned WALK_TIME  = 6,
  parameter int unsigned FLASH_TIME = 3,
  parameter int unsigned FLASH_DIV  = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       botao_pedestre,
  input  logic [1:0] estado,
  output logic       botao,
  output logic       aguarde,
  output logic       andar,
  output logic       parar,
  output logic [3:0] contagem
);

  localparam int unsigned DIV_W = $clog2(FLASH_DIV + 1);

  logic             pedido;
  fase_t            fase;
  fase_t            fase_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic             parar_nxt;
  logic [1:0]       estado_ant;
  logic             vermelho;
  logic             entrada_vermelho;

  debounce_botao #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clock   (clock),
    .reset   (reset),
    .entrada (botao_pedestre),
    .subida  (pedido)
  );

  // Code 11 is not red, so it aborts a walk like green or yellow would.
  assign vermelho         = (estado == VERMELHO);
  assign entrada_vermelho = vermelho && (estado_ant != VERMELHO);

  // Walk lamp is gated by the live light so it can never show against traffic.
  assign andar = (fase == ANDANDO) && vermelho;

  always_comb begin
    fase_nxt  = fase;
    cnt_nxt   = cnt;
    div_nxt   = div;
    parar_nxt = parar;
    case (fase)
      PARADO: begin
        parar_nxt = 1'b1;
        cnt_nxt   = '0;
        if (pedido) fase_nxt = ESPERA;
      end
      ESPERA: begin
        if (entrada_vermelho) begin
          fase_nxt  = ANDANDO;
          cnt_nxt   = CNT_W'(WALK_TIME - 1);
          parar_nxt = 1'b0;
        end
      end
      ANDANDO: begin
        if (!vermelho) begin
          fase_nxt  = PARADO;
          cnt_nxt   = '0;
          parar_nxt = 1'b1;
        end else if (cnt == '0) begin
          fase_nxt  = PISCANDO;
          cnt_nxt   = CNT_W'(FLASH_TIME - 1);
          div_nxt   = DIV_W'(FLASH_DIV - 1);
          parar_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      PISCANDO: begin
        if (!vermelho || cnt == '0) begin
          fase_nxt  = PARADO;
          cnt_nxt   = '0;
          div_nxt   = '0;
          parar_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          if (div == '0) begin
            parar_nxt = ~parar;
            div_nxt   = DIV_W'(FLASH_DIV - 1);
          end else begin
            div_nxt = div - DIV_W'(1);
          end
        end
      end
      default: fase_nxt = PARADO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fase       <= PARADO;
      cnt        <= '0;
      div        <= '0;
      estado_ant <= VERMELHO;
      botao      <= 1'b0;
      aguarde    <= 1'b0;
      parar      <= 1'b1;
      contagem   <= '0;
    end else begin
      fase       <= fase_nxt;
      cnt        <= cnt_nxt;
      div        <= div_nxt;
      estado_ant <= estado;
      botao      <= (fase == ESPERA) && (estado == VERDE);
      aguarde    <= (fase_nxt == ESPERA);
      parar      <= parar_nxt;
      contagem   <= (fase_nxt == ANDANDO || fase_nxt == PISCANDO) ? mostrador(cnt_nxt) : '0;
    end
  end

endmodule

// File: tb/tb_semaforo_pedestre.sv
// Self-checking bench for semaforo_pedestre: directed scenarios followed by
// random button/light traffic, all compared against a phase-level model.
module tb_semaforo_pedestre;
  import semaforo_pkg::*;

  localparam int DEB   = 4;
  localparam int WALK  = 6;
  localparam int FLASH = 3;
  localparam int FDIV  = 1;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_WALK  = 2;
  localparam int M_FLASH = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       botao_pedestre;
  logic [1:0] estado;
  logic       botao;
  logic       aguarde;
  logic       andar;
  logic       parar;
  logic [3:0] contagem;

  int total = 0;
  int bad   = 0;

  // model state
  int ph;
  int left;
  int est_prev;
  bit b1, b2;
  bit sq[$];
  bit level;
  bit req_q;
  bit exp_botao;

  always #5 clock = ~clock;

  semaforo_pedestre #(
    .DEBOUNCE   (DEB),
    .WALK_TIME  (WALK),
    .FLASH_TIME (FLASH),
    .FLASH_DIV  (FDIV)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .botao_pedestre (botao_pedestre),
    .estado         (estado),
    .botao          (botao),
    .aguarde        (aguarde),
    .andar          (andar),
    .parar          (parar),
    .contagem       (contagem)
  );

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    ph = M_IDLE; left = 0; est_prev = 2;
    b1 = 0; b2 = 0; sq.delete(); level = 0; req_q = 0; exp_botao = 0;
  endtask

  // One rising edge of the reference: button history, then the crossing phase.
  task automatic model_edge(input bit b, input logic [1:0] e);
    bit sample, rise, red, entry, flip;
    sample = b2; b2 = b1; b1 = b;
    sq.push_back(sample);
    if (sq.size() > DEB) void'(sq.pop_front());
    rise = 0;
    if (sq.size() == DEB) begin
      flip = 1;
      foreach (sq[i]) if (sq[i] == level) flip = 0;
      if (flip) begin level = ~level; rise = level; end
    end
    red   = (e == 2'b10);
    entry = red && (est_prev != 2);
    exp_botao = (ph == M_WAIT) && (e == 2'b00);
    case (ph)
      M_IDLE:  if (req_q) ph = M_WAIT;
      M_WAIT:  if (entry) begin ph = M_WALK; left = WALK; end
      M_WALK:  if (!red) ph = M_IDLE;
               else if (left == 1) begin ph = M_FLASH; left = FLASH; end
               else left--;
      default: if (!red || left == 1) ph = M_IDLE; else left--;
    endcase
    est_prev = int'(e);
    req_q = rise;
  endtask

  function automatic logic [3:0] exp_cont();
    if (ph == M_WALK || ph == M_FLASH) return (left > 15) ? 4'd15 : 4'(left);
    return 4'd0;
  endfunction

  function automatic logic exp_parar();
    if (ph == M_WALK) return 1'b0;
    if (ph == M_FLASH) return (((FLASH - left) / FDIV) % 2) == 0;
    return 1'b1;
  endfunction

  task automatic check_outputs(input string tag, input logic [1:0] e);
    chk({tag, ".botao"},    4'(botao),    4'(exp_botao));
    chk({tag, ".aguarde"},  4'(aguarde),  4'(ph == M_WAIT));
    chk({tag, ".andar"},    4'(andar),    4'(ph == M_WALK && e == 2'b10));
    chk({tag, ".parar"},    4'(parar),    4'(exp_parar()));
    chk({tag, ".contagem"}, contagem,     exp_cont());
  endtask

  task automatic step(input bit b, input logic [1:0] e, input string tag);
    @(negedge clock);
    botao_pedestre = b;
    estado = e;
    #1;
    chk({tag, ".andar_pre"}, 4'(andar), 4'(ph == M_WALK && e == 2'b10));
    @(posedge clock);
    model_edge(b, e);
    #1;
    check_outputs(tag, e);
  endtask

  initial begin
    int bl, br, er, ei;
    logic [1:0] seq [3];
    logic [1:0] ecur;
    reset = 1'b0;
    botao_pedestre = 1'b0;
    estado = VERMELHO;
    model_reset();
    #16;
    check_outputs("reset", estado);
    reset = 1'b1;

    // short glitch must not register
    step(1, VERDE, "glitch"); step(1, VERDE, "glitch");
    for (int i = 0; i < 8; i++) step(0, VERDE, "glitch");
    chk("glitch.aguarde_end", 4'(aguarde), 4'd0);

    // held press: accepted and forwarded within 8 edges
    for (int i = 1; i <= 10; i++) begin
      step(1, VERDE, "press");
      if (i == 7) chk("press.botao7", 4'(botao), 4'd0);
      if (i == 8) begin
        chk("press.aguarde8", 4'(aguarde), 4'd1);
        chk("press.botao8", 4'(botao), 4'd1);
      end
    end
    for (int i = 0; i < 3; i++) step(0, VERDE, "hold");
    chk("hold.botao", 4'(botao), 4'd1);

    // full walk and flash cycle
    step(0, AMARELO, "amber"); step(0, AMARELO, "amber");
    chk("amber.botao", 4'(botao), 4'd0);
    for (int i = 0; i < 6; i++) begin
      step(0, VERMELHO, "walk");
      chk("walk.andar", 4'(andar), 4'd1);
      chk("walk.cont", contagem, 4'(6 - i));
    end
    for (int j = 0; j < 3; j++) begin
      step(0, VERMELHO, "flash");
      chk("flash.parar", 4'(parar), 4'((j % 2) == 0));
      chk("flash.cont", contagem, 4'(3 - j));
    end
    step(0, VERMELHO, "done");
    chk("done.cont", contagem, 4'd0);
    chk("done.parar", 4'(parar), 4'd1);

    // walk aborted by green on its third cycle
    for (int i = 0; i < 10; i++) step(1, VERDE, "abort_req");
    step(0, VERDE, "abort_req"); step(0, AMARELO, "abort_req");
    step(0, VERMELHO, "abort_walk"); step(0, VERMELHO, "abort_walk");
    step(0, VERDE, "abort");
    chk("abort.cont", contagem, 4'd0);
    chk("abort.aguarde", 4'(aguarde), 4'd0);

    // request while already red waits for a fresh red
    for (int i = 0; i < 10; i++) step(1, VERMELHO, "late_req");
    for (int i = 0; i < 4; i++) begin
      step(0, VERMELHO, "late_wait");
      chk("late_wait.aguarde", 4'(aguarde), 4'd1);
    end
    step(0, VERDE, "late_cyc"); step(0, VERDE, "late_cyc");
    step(0, AMARELO, "late_cyc"); step(0, AMARELO, "late_cyc");
    step(0, VERMELHO, "late_walk");
    chk("late_walk.andar", 4'(andar), 4'd1);
    chk("late_walk.cont", contagem, 4'd6);

    // asynchronous reset in the middle of a walk
    step(0, VERMELHO, "mid"); step(0, VERMELHO, "mid");
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async.andar", 4'(andar), 4'd0);
    check_outputs("async", estado);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(0, VERMELHO, "post_rst");
    chk("post_rst.aguarde", 4'(aguarde), 4'd0);

    // random traffic
    seq[0] = VERDE; seq[1] = AMARELO; seq[2] = VERMELHO;
    bl = 0; br = 0; er = 0; ei = 0; ecur = VERDE;
    for (int n = 0; n < 800; n++) begin
      if (br == 0) begin
        bl = ($urandom_range(0, 2) == 0) ? 1 : 0;
        br = $urandom_range(1, 12);
      end
      if (er == 0) begin
        ei = (ei + 1) % 3;
        ecur = ($urandom_range(0, 9) == 0) ? 2'b11 : seq[ei];
        er = (seq[ei] == VERMELHO) ? $urandom_range(3, 16) : $urandom_range(1, 8);
      end
      step(bit'(bl), ecur, "rand");
      br--; er--;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/semaforo_pedestre.md
SEMAFORO_PEDESTRE -- requirements
Module: semaforo_pedestre

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 4: consecutive equal synchronized samples needed to accept a button level.
REQ-002 SHALL have parameter WALK_TIME, default 6: walk-phase length in cycles.
REQ-003 SHALL have parameter FLASH_TIME, default 3: flashing-phase length in cycles.
REQ-004 SHALL have parameter FLASH_DIV, default 1: cycles per `parar` toggle during flashing.
REQ-005 SHALL have port `clock`, input, 1 bit: the only clock; all logic on its rising edge.
REQ-006 SHALL have port `reset`, input, 1 bit: asynchronous, active-low (0 = reset).
REQ-007 SHALL have port `botao_pedestre`, input, 1 bit: raw, asynchronous pedestrian push-button.
REQ-008 SHALL have port `estado`, input, 2 bits: vehicle-light state, 00 green, 01 yellow, 10 red, 11 invalid.
REQ-009 SHALL have port `botao`, output, 1 bit: request to the vehicle light.
REQ-010 SHALL have port `aguarde`, output, 1 bit: "request registered" lamp.
REQ-011 SHALL have port `andar`, output, 1 bit: walk lamp.
REQ-012 SHALL have port `parar`, output, 1 bit: don't-walk lamp.
REQ-013 SHALL have port `contagem`, output, 4 bits: remaining-phase countdown display.

Function
REQ-014 SHALL pass `botao_pedestre` through a 2-flop synchronizer.
REQ-015 SHALL change the debounced level only after DEBOUNCE consecutive equal samples; any differing sample restarts the count.
REQ-016 SHALL raise a request event on each 0->1 edge of the debounced level.
REQ-017 SHALL register `estado` each cycle as `estado_ant`; "red entry" = (estado==10) && (estado_ant!=10).
REQ-018 SHALL implement FSM states PARADO, ESPERA, ANDANDO, PISCANDO.
REQ-019 PARADO: request event -> ESPERA; red without a request stays PARADO.
REQ-020 ESPERA: red entry -> ANDANDO; red already present on ESPERA entry is ignored until the next red entry.
REQ-021 ANDANDO: counter loaded WALK_TIME-1 on entry, decrements each cycle; at 0 -> PISCANDO.
REQ-022 PISCANDO: counter loaded FLASH_TIME-1 on entry, decrements each cycle; at 0 -> PARADO.
REQ-023 In ANDANDO or PISCANDO, estado!=10 -> PARADO on the next edge; request events there are discarded.
REQ-024 `botao` SHALL be registered: 1 in the cycle after any edge where state is ESPERA and estado==00, else 0 (held, not pulsed).
REQ-025 `aguarde` SHALL be 1 exactly while state is ESPERA.
REQ-026 `andar` SHALL be (state==ANDANDO) AND (estado==10) combinationally, never 1 while the vehicle light is not red.
REQ-027 `parar` SHALL be 1 in PARADO/ESPERA, 0 in ANDANDO, and in PISCANDO start at 1 and toggle every FLASH_DIV cycles.
REQ-028 `contagem` SHALL show counter+1 in ANDANDO/PISCANDO, 0 otherwise; saturate at 15.
REQ-029 estado==11 SHALL be treated as not-red.

Reset
REQ-030 While reset==0: state PARADO, counters 0, debounced level 0, `estado_ant` 10, `botao` 0, `aguarde` 0, `andar` 0, `parar` 1, `contagem` 0.
REQ-031 Reset mid-walk SHALL drop `andar` immediately (asynchronously) and discard any pending request.

Structure
REQ-032 FSM state encoding and estado constants VERDE=00, AMARELO=01, VERMELHO=10 SHALL live in shared package semaforo_pkg.
REQ-033 Debounce (REQ-014..016) SHALL be a sub-module `debounce_botao` with a one-cycle rising-edge output.

Verification
REQ-034 Button high 2 cycles, estado=00 -> no request, `aguarde` stays 0.
REQ-035 Button held 10 cycles, estado=00 -> `aguarde`=1 and `botao`=1 within 2+4+2 cycles; `botao` stays 1 until estado leaves 00.
REQ-036 From ESPERA, estado 01 -> 10 -> walk: `andar`=1 for 6 cycles with `contagem` 6..1, then `parar` flashes 1,0,1 with `contagem` 3..1, then PARADO.
REQ-037 estado forced to 00 on the 3rd walk cycle -> `andar`=0 in that same cycle, state PARADO on the next edge.
REQ-038 Request while estado already 10 -> stay ESPERA, no walk until estado cycles 10 -> 00 -> 01 -> 10.
REQ-039 reset=0 asserted mid-ANDANDO -> outputs jump to REQ-030 values without a clock edge; after release, `aguarde`=0.
